// File: rtl/direction_ctrl.sv
// Direction controller for an up/down counter.
// Two raw push-buttons are synchronized, debounced, and edge-detected. The resulting
// press events drive a two-state FSM whose state register is the direction output.
// A button must hold a new level for DEBOUNCE_CYCLES consecutive edges before the
// change is accepted.
module direction_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_DIR       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic direction,
    output logic dir_change,
    output logic conflict
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the up button, bit 1 the down button, through every stage.
    localparam int unsigned UP = 0;
    localparam int unsigned DN = 1;

    typedef enum logic {
        S_DOWN = 1'b0,
        S_UP   = 1'b1
    } state_t;

    logic [1:0]       btn_raw;
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [1:0]       deb_prev_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;

    state_t state_q;
    state_t state_d;
    logic   dir_change_q;
    logic   dir_change_d;
    logic   conflict_q;
    logic   conflict_d;

    assign btn_raw = {btn_down, btn_up};

    // Two-flop synchronizer per button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    // Debounce next-state: count consecutive mismatching edges, accept on the last one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels, their one-cycle history, and the per-button counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A press is a rising debounced level; releases are ignored.
    assign press = deb_q & ~deb_prev_q;

    // FSM next-state and pulse outputs; simultaneous presses are rejected as a conflict.
    always_comb begin
        state_d      = state_q;
        dir_change_d = 1'b0;
        conflict_d   = 1'b0;
        if (press[UP] && press[DN]) begin
            conflict_d = 1'b1;
        end else begin
            case (state_q)
                S_DOWN: begin
                    if (press[UP]) begin
                        state_d      = S_UP;
                        dir_change_d = 1'b1;
                    end
                end
                S_UP: begin
                    if (press[DN]) begin
                        state_d      = S_DOWN;
                        dir_change_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= state_t'(RESET_DIR);
            dir_change_q <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_change_q <= dir_change_d;
            conflict_q   <= conflict_d;
        end
    end

    // Direction is the state flop itself, so it cannot glitch.
    assign direction  = (state_q == S_UP);
    assign dir_change = dir_change_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Self-checking bench for direction_ctrl with default parameters.
module tb_direction_ctrl;

    logic clk;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic direction;
    logic dir_change;
    logic conflict;

    int checks   = 0;
    int failures = 0;

    direction_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RESET_DIR      (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .direction (direction),
        .dir_change(dir_change),
        .conflict  (conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One stimulus vector: levels held for hi edges, then low for lo edges.
    typedef struct {
        string name;
        logic  up;
        logic  down;
        int    hi;
        int    lo;
        logic  exp_dir;
        int    exp_chg;
        int    exp_cfl;
        int    exp_lat;  // edges after first sampling until direction flips, -1 for never
    } vec_t;

    typedef struct {
        string name;
        logic  dir;
        int    chg;
        int    cfl;
        int    lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic up, input logic down,
                           input int hi, input int lo, input logic exp_dir,
                           input int exp_chg, input int exp_cfl, input int exp_lat);
        vec_t v;
        v.name    = name;
        v.up      = up;
        v.down    = down;
        v.hi      = hi;
        v.lo      = lo;
        v.exp_dir = exp_dir;
        v.exp_chg = exp_chg;
        v.exp_cfl = exp_cfl;
        v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Drive one vector, push its expectation, observe, then pop and compare.
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        logic start_dir;
        int   chg;
        int   cfl;
        int   both;
        int   lat;
        int   misalign;
        e.name = v.name;
        e.dir  = v.exp_dir;
        e.chg  = v.exp_chg;
        e.cfl  = v.exp_cfl;
        e.lat  = v.exp_lat;
        sb.push_back(e);
        chg      = 0;
        cfl      = 0;
        both     = 0;
        lat      = -1;
        misalign = 0;
        @(negedge clk);
        start_dir = direction;
        btn_up    = v.up;
        btn_down  = v.down;
        for (int j = 1; j <= v.hi + v.lo; j++) begin
            @(negedge clk);
            if (dir_change) chg++;
            if (conflict) cfl++;
            if (dir_change && conflict) both++;
            if (lat < 0 && direction != start_dir) begin
                lat = j - 1;
                if (!dir_change) misalign++;
            end
            if (j == v.hi) begin
                btn_up   = 1'b0;
                btn_down = 1'b0;
            end
        end
        got = sb.pop_front();
        check({got.name, " direction"}, int'(direction), int'(got.dir));
        check({got.name, " dir_change pulses"}, chg, got.chg);
        check({got.name, " conflict pulses"}, cfl, got.cfl);
        check({got.name, " latency"}, lat, got.lat);
        check({got.name, " pulse overlap"}, both, 0);
        check({got.name, " dir_change aligned"}, misalign, 0);
    endtask

    initial begin
        int chg;
        int cfl;
        int bad_dir;
        int lat;

        add_vec("up_press",        1'b1, 1'b0, 20, 10, 1'b1, 1, 0,  6);
        add_vec("down_glitch",     1'b0, 1'b1,  3, 10, 1'b1, 0, 0, -1);
        add_vec("up_same_dir",     1'b1, 1'b0, 20, 10, 1'b1, 0, 0, -1);
        add_vec("conflict_up",     1'b1, 1'b1, 10, 10, 1'b1, 0, 1, -1);
        add_vec("down_press",      1'b0, 1'b1, 20, 10, 1'b0, 1, 0,  6);
        add_vec("down_same_dir",   1'b0, 1'b1, 20, 10, 1'b0, 0, 0, -1);
        add_vec("up_glitch",       1'b1, 1'b0,  3, 10, 1'b0, 0, 0, -1);
        add_vec("up_min_hold",     1'b1, 1'b0,  4, 10, 1'b1, 1, 0,  6);
        add_vec("down_press2",     1'b0, 1'b1, 20, 10, 1'b0, 1, 0,  6);
        add_vec("conflict_down",   1'b1, 1'b1, 10, 10, 1'b0, 0, 1, -1);
        add_vec("up_press2",       1'b1, 1'b0, 20, 10, 1'b1, 1, 0,  6);

        // Asynchronous reset takes effect before any clock edge.
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("reset direction", int'(direction), 0);
        check("reset dir_change", int'(dir_change), 0);
        check("reset conflict", int'(conflict), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset direction", int'(direction), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset two edges into a down debounce while in S_UP; partial count is dropped.
        @(negedge clk);
        btn_down = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset direction", int'(direction), 0);
        check("midreset dir_change", int'(dir_change), 0);
        check("midreset conflict", int'(conflict), 0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        chg     = 0;
        cfl     = 0;
        bad_dir = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (dir_change) chg++;
            if (conflict) cfl++;
            if (direction != 1'b0) bad_dir++;
            if (j == 20) btn_down = 1'b0;
        end
        check("midreset later dir_change", chg, 0);
        check("midreset later conflict", cfl, 0);
        check("midreset direction held", bad_dir, 0);

        // Button already held when reset releases counts as one press.
        btn_up = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chg = 0;
        lat = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (dir_change) chg++;
            if (lat < 0 && direction == 1'b1) lat = j - 1;
            if (j == 20) btn_up = 1'b0;
        end
        check("held-at-reset latency", lat, 6);
        check("held-at-reset dir_change", chg, 1);
        check("held-at-reset direction", int'(direction), 1);
        check("scoreboard drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
